// File: rtl/sid_filter_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sid_filter_pkg - shared constants, state encoding and saturation helper
// Revision: 1.0
// -----------------------------------------------------------------------------
package sid_filter_pkg;

  localparam int W0_SCALE = 82355;

  localparam int Q_TABLE [16] = '{1448, 1328, 1218, 1117, 1024, 939, 861, 790,
                                  724, 664, 609, 558, 512, 470, 431, 395};

  typedef logic signed [63:0] wide_t;

`ifdef SID_FILTER_DCBLOCK_EN
  typedef enum logic [3:0] {
    S_IDLE, S_SUM, S_BP, S_LP, S_HP, S_MIX, S_VOL, S_DCB, S_OUT
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_SUM, S_BP, S_LP, S_HP, S_MIX, S_VOL, S_OUT
  } state_t;
`endif

  function automatic wide_t sat_wide(input wide_t x, input int w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sid_filter_mul.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sid_filter_mul - registered signed W x W multiplier with enable (holds when idle)
// Revision: 1.0
// -----------------------------------------------------------------------------
module sid_filter_mul #(
  parameter int W = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic signed [2*W-1:0] p
);

  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
    end else if (en) begin
      p <= (2*W)'(a) * (2*W)'(b);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sid_filter_mc.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sid_filter_mc - multi-voice SID state-variable filter, one shared multiplier
// Optional DC blocker: define SID_FILTER_DCBLOCK_EN.             Revision: 1.0
// -----------------------------------------------------------------------------
module sid_filter_mc
  import sid_filter_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int VOICE_W    = 12,
  parameter int ACC_W      = 18
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [10:0]                   fc,
  input  logic [3:0]                    res,
  input  logic [NUM_VOICES:0]           filt_route,
  input  logic [3:0]                    mode,
  input  logic [3:0]                    vol,
  input  logic                          ext_en,
  input  logic [NUM_VOICES*VOICE_W-1:0] voices,
  input  logic [VOICE_W-1:0]            ext_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic signed [15:0]            sound,
  output logic                          clip
);

  localparam int SRC_W = (NUM_VOICES + 1) * VOICE_W;
  localparam int PW    = 2 * ACC_W;
  localparam int HALF  = 1 << (VOICE_W - 1);

  state_t state, state_next;
  logic [3:0]                idx;
  logic [SRC_W-1:0]          src_q;
  logic [NUM_VOICES:0]       route_q;
  logic [3:0]                mode_q, vol_q;
  logic                      ext_en_q;
  logic [10:0]               fc_q;
  logic signed [ACC_W-1:0]   q_q, w0, vi, vnf, vhp, vbp, vlp, mix;

  logic                      mul_en;
  logic signed [ACC_W-1:0]   mul_a, mul_b;
  logic signed [PW-1:0]      prod;

  logic [VOICE_W-1:0]        src;
  logic                      route_bit, mute;
  logic signed [ACC_W-1:0]   contrib;
  wide_t prod_w, bp_w, lp_w, hp_w, vf_w, mix_w, snd_w;
  wide_t bp_s, lp_s, hp_s, mix_s, snd_s;
`ifdef SID_FILTER_DCBLOCK_EN
  logic signed [15:0]        dcb_x1, dcb_y1;
  wide_t dcb_w, dcb_s;
`endif

  sid_filter_mul #(.W(ACC_W)) u_mul (
    .clk (clk),
    .rst (rst),
    .en  (mul_en),
    .a   (mul_a),
    .b   (mul_b),
    .p   (prod)
  );

  // Datapath: every step result is formed from the product of the previous state.
  always_comb begin
    src       = VOICE_W'(src_q >> (int'(idx) * VOICE_W));
    route_bit = ((route_q >> idx) & (NUM_VOICES + 1)'(1)) != '0;
    mute      = (NUM_VOICES > 2) && (idx == 4'd2) && mode_q[3] && !route_bit;
    contrib   = (ACC_W'(src) - ACC_W'(HALF)) <<< 2;

    prod_w = wide_t'(prod);
    bp_w   = wide_t'(vbp) - (prod_w >>> 19);
    lp_w   = wide_t'(vlp) - (prod_w >>> 19);
    hp_w   = (prod_w >>> 10) - wide_t'(vlp) - wide_t'(vi);
    bp_s   = sat_wide(bp_w, ACC_W);
    lp_s   = sat_wide(lp_w, ACC_W);
    hp_s   = sat_wide(hp_w, ACC_W);

    vf_w = '0;
    if (mode_q[0]) vf_w = vf_w + wide_t'(vlp);
    if (mode_q[1]) vf_w = vf_w + wide_t'(vbp);
    if (mode_q[2]) vf_w = vf_w + hp_s;
    mix_w = ext_en_q ? (wide_t'(vnf) - vf_w) : (wide_t'(vi) + wide_t'(vnf));
    mix_s = sat_wide(mix_w, ACC_W);

    snd_w = prod_w >>> 5;
    snd_s = sat_wide(snd_w, 16);
`ifdef SID_FILTER_DCBLOCK_EN
    dcb_w = snd_s - wide_t'(dcb_x1) + wide_t'(dcb_y1) - (wide_t'(dcb_y1) >>> 8);
    dcb_s = sat_wide(dcb_w, 16);
`endif
  end

  always_comb begin
    state_next = state;
    in_ready   = (state == S_IDLE);
    mul_en     = 1'b0;
    mul_a      = '0;
    mul_b      = '0;
    case (state)
      S_IDLE: if (in_valid) state_next = S_SUM;
      S_SUM: begin
        if (idx == 4'd0) begin
          mul_en = 1'b1;
          mul_a  = ACC_W'(W0_SCALE);
          mul_b  = ACC_W'(fc_q) + ACC_W'(1);
        end
        if (idx == 4'(NUM_VOICES)) state_next = S_BP;
      end
      S_BP: begin
        mul_en = 1'b1; mul_a = w0; mul_b = vhp; state_next = S_LP;
      end
      S_LP: begin
        mul_en = 1'b1; mul_a = w0; mul_b = ACC_W'(bp_s); state_next = S_HP;
      end
      S_HP: begin
        mul_en = 1'b1; mul_a = q_q; mul_b = vbp; state_next = S_MIX;
      end
      S_MIX: state_next = S_VOL;
      S_VOL: begin
        mul_en = 1'b1; mul_a = mix; mul_b = ACC_W'(vol_q);
`ifdef SID_FILTER_DCBLOCK_EN
        state_next = S_DCB;
`else
        state_next = S_OUT;
`endif
      end
`ifdef SID_FILTER_DCBLOCK_EN
      S_DCB: state_next = S_OUT;
`endif
      S_OUT: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      src_q     <= '0;
      route_q   <= '0;
      mode_q    <= '0;
      vol_q     <= '0;
      ext_en_q  <= 1'b0;
      fc_q      <= '0;
      q_q       <= '0;
      w0        <= '0;
      vi        <= '0;
      vnf       <= '0;
      vhp       <= '0;
      vbp       <= '0;
      vlp       <= '0;
      mix       <= '0;
      out_valid <= 1'b0;
      sound     <= '0;
      clip      <= 1'b0;
`ifdef SID_FILTER_DCBLOCK_EN
      dcb_x1    <= '0;
      dcb_y1    <= '0;
`endif
    end else begin
      state     <= state_next;
      out_valid <= 1'b0;
      case (state)
        S_IDLE: if (in_valid) begin
          src_q    <= {ext_in, voices};
          route_q  <= filt_route;
          mode_q   <= mode;
          vol_q    <= vol;
          ext_en_q <= ext_en;
          fc_q     <= fc;
          q_q      <= ACC_W'(Q_TABLE[res]);
          vi       <= '0;
          vnf      <= '0;
          idx      <= '0;
        end
        S_SUM: begin
          idx <= idx + 4'd1;
          // Cutoff product was launched on the first source cycle.
          if (idx == 4'd1) w0 <= ACC_W'(prod_w >>> 12);
          if (!mute) begin
            if (route_bit) vi  <= vi + contrib;
            else           vnf <= vnf + contrib;
          end
        end
        S_LP: begin
          vbp <= ACC_W'(bp_s);
          if (bp_s != bp_w) clip <= 1'b1;
        end
        S_HP: begin
          vlp <= ACC_W'(lp_s);
          if (lp_s != lp_w) clip <= 1'b1;
        end
        S_MIX: begin
          vhp <= ACC_W'(hp_s);
          mix <= ACC_W'(mix_s);
          if ((hp_s != hp_w) || (mix_s != mix_w)) clip <= 1'b1;
        end
`ifdef SID_FILTER_DCBLOCK_EN
        S_DCB: begin
          dcb_x1 <= 16'(snd_s);
          dcb_y1 <= 16'(dcb_s);
          if ((snd_s != snd_w) || (dcb_s != dcb_w)) clip <= 1'b1;
        end
        S_OUT: begin
          sound     <= dcb_y1;
          out_valid <= 1'b1;
        end
`else
        S_OUT: begin
          sound     <= 16'(snd_s);
          out_valid <= 1'b1;
          if (snd_s != snd_w) clip <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sid_filter_mc.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_sid_filter_mc - directed bench for sid_filter_mc (3-voice and 8-voice builds)
// Revision: 1.0
// -----------------------------------------------------------------------------
module tb_sid_filter_mc;
  import sid_filter_pkg::*;

  localparam int NV  = 3;
  localparam int NVB = 8;
  localparam int VW  = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [10:0]        fc;
  logic [3:0]         res, mode, vol;
  logic               ext_en, in_valid, in_ready, out_valid, clip;
  logic [NV:0]        route;
  logic [NV*VW-1:0]   voices;
  logic [VW-1:0]      ext_in;
  logic signed [15:0] sound;

  logic [3:0]         b_mode, b_vol;
  logic               b_ext_en, b_in_valid, b_in_ready, b_out_valid, b_clip;
  logic [NVB:0]       b_route;
  logic [NVB*VW-1:0]  b_voices;
  logic [VW-1:0]      b_ext_in;
  logic signed [15:0] b_sound;

  int checks = 0;
  int errors = 0;

  sid_filter_mc #(.NUM_VOICES(NV), .VOICE_W(VW), .ACC_W(18)) dut_a (
    .clk(clk), .rst(rst), .fc(fc), .res(res), .filt_route(route), .mode(mode),
    .vol(vol), .ext_en(ext_en), .voices(voices), .ext_in(ext_in),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .sound(sound), .clip(clip)
  );

  sid_filter_mc #(.NUM_VOICES(NVB), .VOICE_W(VW), .ACC_W(18)) dut_b (
    .clk(clk), .rst(rst), .fc(11'd0), .res(4'd0), .filt_route(b_route), .mode(b_mode),
    .vol(b_vol), .ext_en(b_ext_en), .voices(b_voices), .ext_in(b_ext_in),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_valid(b_out_valid),
    .sound(b_sound), .clip(b_clip)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expected);
    checks++;
    assert (obs === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one sample on dut_a; optionally disturb inputs right after acceptance.
  task automatic send_a(input bit scramble, output int lat);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin tick(); guard++; end
    tick();
    in_valid = 1'b0;
    if (scramble) begin
      voices = '0;
      vol    = 4'd0;
      route  = '1;
    end
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
  endtask

  task automatic send_b(output int lat);
    int guard;
    guard      = 0;
    b_in_valid = 1'b1;
    while (!b_in_ready && guard < 50) begin tick(); guard++; end
    tick();
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 100) begin tick(); lat++; end
  endtask

  initial begin
    int lat;
    int ov_seen;
    int gap;
    logic signed [15:0] s2;
    logic signed [15:0] s199;

    rst = 1'b1; in_valid = 1'b0; fc = '0; res = '0; mode = '0; vol = '0;
    ext_en = 1'b0; route = '0; voices = {NV{12'h800}}; ext_in = 12'h800;
    b_in_valid = 1'b0; b_mode = '0; b_vol = '0; b_ext_en = 1'b0; b_route = '0;
    b_voices = {NVB{12'h800}}; b_ext_in = 12'h800;
    repeat (3) tick();
    rst = 1'b0;

    ov_seen = 0;
    repeat (5) begin tick(); if (out_valid) ov_seen++; end
    check("reset_sound", sound, 0);
    check("reset_clip", clip, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_no_out_valid", ov_seen, 0);

    // Silent inputs: latency and zero output
    vol = 4'd15;
    send_a(1'b0, lat);
    check("silent_latency", lat, NV + 7);
    check("silent_sound", sound, 0);
    check("ready_at_pulse", in_ready, 1);
    tick();
    check("pulse_one_cycle", out_valid, 0);

    // Single full-scale voice bypassed, inputs disturbed after accept
    voices = {NV{12'h800}}; voices[11:0] = 12'hFFF; route = '0;
    ext_en = 1'b1; vol = 4'd8; mode = 4'b0001;
    send_a(1'b1, lat);
    check("v0_ext_en1_sound", sound, 2047);
    voices = {NV{12'h800}}; voices[11:0] = 12'hFFF; route = '0;
    ext_en = 1'b0; vol = 4'd8;
    send_a(1'b0, lat);
    check("v0_ext_en0_sound", sound, 2047);
    vol = 4'd0;
    send_a(1'b0, lat);
    check("vol_zero_sound", sound, 0);

    // Voice-3 mute on unfiltered path
    voices = {NV{12'hFFF}}; ext_in = 12'h800; route = '0; vol = 4'd8; mode = 4'b0000;
    send_a(1'b0, lat);
    check("three_voices_sound", sound, 6141);
    mode = 4'b1000;
    send_a(1'b0, lat);
    check("v3off_sound", sound, 4094);

    // Back-to-back with in_valid held high
    voices = {NV{12'h800}}; mode = '0; vol = 4'd0;
    in_valid = 1'b1;
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    gap = 0;
    do begin tick(); gap++; end while (!out_valid && gap < 100);
    in_valid = 1'b0;
    check("throughput_gap", gap, NV + 8);
    repeat (NV + 10) tick();

    // Low-pass step response
    rst = 1'b1; tick(); rst = 1'b0;
    voices = {NV{12'h800}}; voices[11:0] = 12'hFFF; ext_in = 12'h800;
    route = 4'b0001; mode = 4'b0001; fc = 11'h7FF; res = 4'd0; ext_en = 1'b1; vol = 4'd15;
    send_a(1'b0, lat);
    check("lp_step1_sound", sound, 0);
    send_a(1'b0, lat);
    check("lp_step2_sound", sound, 23);
    s2 = sound;
    s199 = '0;
    for (int i = 3; i <= 200; i++) begin
      send_a(1'b0, lat);
      if (i == 199) s199 = sound;
    end
    check("lp_rises", sound > s2, 1);
    check("lp_final_low", sound >= 16'sd3798, 1);
    check("lp_final_high", sound <= 16'sd3878, 1);
    check("lp_settled", ((sound - s199) <= 16'sd10) && ((s199 - sound) <= 16'sd10), 1);
    check("lp_no_clip", clip, 0);

    // Reset while in S_LP aborts the step
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    repeat (NV + 2) tick();
    check("reached_s_lp", dut_a.state, S_LP);
    rst = 1'b1; tick(); rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_vlp", dut_a.vlp, 0);
    check("abort_vbp", dut_a.vbp, 0);
    check("abort_vhp", dut_a.vhp, 0);
    check("abort_sound", sound, 0);
    ov_seen = 0;
    repeat (20) begin if (out_valid) ov_seen++; tick(); end
    check("abort_no_out_valid", ov_seen, 0);

    // Eight voices + ext full-scale saturates the output
    b_voices = {NVB{12'hFFF}}; b_ext_in = 12'hFFF; b_route = '0;
    b_vol = 4'd15; b_ext_en = 1'b0; b_mode = '0;
    check("b_clip_before", b_clip, 0);
    send_b(lat);
    check("b_latency", lat, NVB + 7);
    check("b_sound_sat", b_sound, 32767);
    check("b_clip_after", b_clip, 1);
    check("a_clip_untouched", clip, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
